laser_scan_sched: RTL and testbench
===================================

Name: laser_scan_sched

Overview:
- Scan scheduler for the two-circle laser coverage search.
- Sequences one shared coverage-count engine through alternating raster scans: C1 moves while C2 is fixed, then C2 moves while C1 is fixed.
- After each scan the moving circle is committed to its best position. Scans repeat until an iteration changes neither circle, or until MAX_ITER iterations.
- Sits between the point-storage/count datapath (engine) and the top-level DONE/C1/C2 interface.

Parameters:
- MAX_ITER, 8, maximum C1+C2 iteration pairs before forced finish (1..15).
- CNT_W, 6, width of engine coverage count (40 points max).

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- START  in  1  one-cycle pulse; begins a search (ignored when BUSY=1)
- EVAL_REQ  out  1  candidate evaluation request to engine
- EVAL_CX  out  4  candidate x of moving circle
- EVAL_CY  out  4  candidate y of moving circle
- EVAL_SEL  out  1  moving circle: 0=C1, 1=C2
- EVAL_ACK  in  1  engine accepted request this cycle
- RES_VALID  in  1  engine count valid this cycle
- RES_COUNT  in  CNT_W  points covered by the union of (candidate, fixed circle)
- C1X, C1Y, C2X, C2Y  out  4 each  committed circle centres; the engine reads the fixed circle from these
- BUSY  out  1  search in progress
- ITER  out  4  completed iterations of the current or last search
- DONE  out  1  one-cycle pulse when the final C1/C2 are valid

Behaviour:
- Reset (RST=1 at the CLK edge): state IDLE; C1X=C1Y=C2X=C2Y=0; EVAL_REQ=0; EVAL_CX=EVAL_CY=0; EVAL_SEL=0; BUSY=0; ITER=0; DONE=0. Reset mid-search aborts immediately; no DONE.
- States: IDLE, ISSUE, WAIT, COMMIT, FINISH.
- IDLE, on START:
  - C1/C2 <- (0,0); ITER <- 0; EVAL_SEL <- 0; candidate <- (0,0).
  - best_count <- 0; best_pos <- position of moving circle; changed <- 0; BUSY <- 1; go ISSUE.
- ISSUE: EVAL_REQ=1; EVAL_CX/CY/SEL held stable until EVAL_ACK=1. On ACK go WAIT; EVAL_REQ drops next cycle.
- WAIT:
  - RES_VALID is sampled only in WAIT; pulses in other states are ignored. Engine latency is >=1 cycle after ACK.
  - On RES_VALID, if RES_COUNT > best_count (strict): best_count <- RES_COUNT, best_pos <- candidate. The earliest raster position wins ties.
  - If candidate=(15,15), go COMMIT. Otherwise candidate <- {CY,CX}+1 (x fastest, wraps to next row), go ISSUE.
  - Minimum 2 cycles per candidate; 256 candidates per scan.
- COMMIT (1 cycle):
  - Moving circle <- best_pos. If best_pos differs from its previous value, changed <- 1.
  - If EVAL_SEL=0: EVAL_SEL <- 1; candidate <- (0,0); best_count <- 0; best_pos <- current C2; go ISSUE.
  - If EVAL_SEL=1: ITER <- ITER+1 (saturates at 15).
    - If changed=1 and ITER+1 < MAX_ITER: EVAL_SEL <- 0, changed <- 0, re-initialise the scan, go ISSUE.
    - Otherwise go FINISH.
- FINISH: DONE=1 for exactly one cycle; BUSY <- 0; go IDLE. C1/C2/ITER hold until the next START or RST.
- START while BUSY=1 is ignored. START in the same cycle as RST: reset wins.
- best_count is CNT_W bits; no overflow is possible because RES_COUNT <= 2^CNT_W-1.

Test Plan:
- Reset: RST high 2 cycles, then low, no START -> all outputs 0; BUSY=0; DONE never asserts over 100 cycles.
- Basic convergence, MAX_ITER=8, ACK same cycle, result 1 cycle later:
  - Model: sel0 returns 10 at (5,7) else 3; sel1 returns 12 at (12,3) else 10.
  - Required: C1=(5,7), C2=(12,3) after iteration 1; iteration 2 unchanged; DONE pulses once; ITER=2.
  - Total cycles START->DONE = 4x256x2 + 4 COMMIT + 1 (+/-1 for IDLE/FINISH).
- Tie-break: sel0 returns 9 at both (3,3) and (9,9), else 0 -> C1=(3,3).
- Backpressure: ACK withheld 3 cycles on every request, RES_VALID 4 cycles after ACK -> EVAL_REQ/CX/CY/SEL stable while waiting; same final C1/C2 as the basic-convergence case; stray RES_VALID during ISSUE ignored.
- Non-convergence, MAX_ITER=3: model moves the peak every pass (iteration k peak at (k,k)) -> DONE after exactly 3 iterations; ITER=3; C1/C2 = iteration-3 best positions.
- Abort and restart: RST asserted mid-way through the C2 scan -> next cycle all outputs 0, no DONE. START pulsed while BUSY=1 -> no restart (candidate sequence continues). A fresh START after completion reproduces the basic-convergence result.

Source files
------------

// File: rtl/laser_scan_sched.sv
// laser_scan_sched: drives a shared coverage-count engine through alternating
// raster scans (C1 moving, then C2 moving), commits the best position of the
// moving circle after each scan, and repeats until an iteration leaves both
// circles unchanged or the iteration limit is reached.
module laser_scan_sched #(
    parameter int MAX_ITER = 8,
    parameter int CNT_W    = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    output logic             EVAL_REQ,
    output logic [3:0]       EVAL_CX,
    output logic [3:0]       EVAL_CY,
    output logic             EVAL_SEL,
    input  logic             EVAL_ACK,
    input  logic             RES_VALID,
    input  logic [CNT_W-1:0] RES_COUNT,
    output logic [3:0]       C1X,
    output logic [3:0]       C1Y,
    output logic [3:0]       C2X,
    output logic [3:0]       C2Y,
    output logic             BUSY,
    output logic [3:0]       ITER,
    output logic             DONE
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        COMMIT = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         cand_q, cand_d;          // {y, x}, x increments fastest
    logic               sel_q, sel_d;
    logic [CNT_W-1:0]   best_count_q, best_count_d;
    logic [7:0]         best_pos_q, best_pos_d;  // {y, x}
    logic               changed_q, changed_d;
    logic [3:0]         iter_q, iter_d;
    logic [7:0]         c1_q, c1_d;              // {y, x}
    logic [7:0]         c2_q, c2_d;              // {y, x}

    // Position of the moving circle before this commit, and whether the
    // iteration has moved anything once this commit is included.
    logic [7:0]         moving_prev;
    logic               changed_now;
    logic [4:0]         iter_inc;

    assign moving_prev = sel_q ? c2_q : c1_q;
    assign changed_now = changed_q | (best_pos_q != moving_prev);
    assign iter_inc    = {1'b0, iter_q} + 5'd1;

    assign EVAL_REQ = (state_q == ISSUE);
    assign EVAL_CX  = cand_q[3:0];
    assign EVAL_CY  = cand_q[7:4];
    assign EVAL_SEL = sel_q;
    assign C1X      = c1_q[3:0];
    assign C1Y      = c1_q[7:4];
    assign C2X      = c2_q[3:0];
    assign C2Y      = c2_q[7:4];
    assign BUSY     = (state_q != IDLE);
    assign ITER     = iter_q;
    assign DONE     = (state_q == FINISH);

    // State and datapath registers; reset returns everything to zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            cand_q       <= 8'd0;
            sel_q        <= 1'b0;
            best_count_q <= '0;
            best_pos_q   <= 8'd0;
            changed_q    <= 1'b0;
            iter_q       <= 4'd0;
            c1_q         <= 8'd0;
            c2_q         <= 8'd0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            sel_q        <= sel_d;
            best_count_q <= best_count_d;
            best_pos_q   <= best_pos_d;
            changed_q    <= changed_d;
            iter_q       <= iter_d;
            c1_q         <= c1_d;
            c2_q         <= c2_d;
        end
    end

    // Next-state and datapath updates for the scan sequencer.
    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        sel_d        = sel_q;
        best_count_d = best_count_q;
        best_pos_d   = best_pos_q;
        changed_d    = changed_q;
        iter_d       = iter_q;
        c1_d         = c1_q;
        c2_d         = c2_q;

        unique case (state_q)
            IDLE: begin
                if (START) begin
                    c1_d         = 8'd0;
                    c2_d         = 8'd0;
                    iter_d       = 4'd0;
                    sel_d        = 1'b0;
                    cand_d       = 8'd0;
                    best_count_d = '0;
                    best_pos_d   = 8'd0;   // C1 is being cleared to (0,0)
                    changed_d    = 1'b0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (EVAL_ACK) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (RES_VALID) begin
                    // Strict compare keeps the earliest raster position on ties.
                    if (RES_COUNT > best_count_q) begin
                        best_count_d = RES_COUNT;
                        best_pos_d   = cand_q;
                    end
                    if (cand_q == 8'hFF) begin
                        state_d = COMMIT;
                    end else begin
                        cand_d  = cand_q + 8'd1;
                        state_d = ISSUE;
                    end
                end
            end
            COMMIT: begin
                changed_d = changed_now;
                if (!sel_q) begin
                    c1_d         = best_pos_q;
                    sel_d        = 1'b1;
                    cand_d       = 8'd0;
                    best_count_d = '0;
                    best_pos_d   = c2_q;
                    state_d      = ISSUE;
                end else begin
                    c2_d   = best_pos_q;
                    iter_d = (iter_q == 4'd15) ? 4'd15 : iter_inc[3:0];
                    if (changed_now && (iter_inc < 5'(MAX_ITER))) begin
                        sel_d        = 1'b0;
                        changed_d    = 1'b0;
                        cand_d       = 8'd0;
                        best_count_d = '0;
                        best_pos_d   = c1_q;
                        state_d      = ISSUE;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_laser_scan_sched.sv
// Testbench for laser_scan_sched: a behavioural coverage engine answers the
// scheduler's requests from a per-test score table; tasks check results.
module tb_laser_scan_sched;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RST, start, use3;
    logic ack_drv, rv_drv;
    logic [5:0] rc_drv;

    logic req8, sel8, busy8, done8, req3, sel3, busy3, done3;
    logic [3:0] cx8, cy8, c1x8, c1y8, c2x8, c2y8, iter8;
    logic [3:0] cx3, cy3, c1x3, c1y3, c2x3, c2y3, iter3;

    laser_scan_sched #(.MAX_ITER(8), .CNT_W(6)) dut (
        .CLK(CLK), .RST(RST), .START(start & ~use3),
        .EVAL_REQ(req8), .EVAL_CX(cx8), .EVAL_CY(cy8), .EVAL_SEL(sel8),
        .EVAL_ACK(ack_drv & ~use3), .RES_VALID(rv_drv & ~use3), .RES_COUNT(rc_drv),
        .C1X(c1x8), .C1Y(c1y8), .C2X(c2x8), .C2Y(c2y8),
        .BUSY(busy8), .ITER(iter8), .DONE(done8)
    );

    laser_scan_sched #(.MAX_ITER(3), .CNT_W(6)) dut3 (
        .CLK(CLK), .RST(RST), .START(start & use3),
        .EVAL_REQ(req3), .EVAL_CX(cx3), .EVAL_CY(cy3), .EVAL_SEL(sel3),
        .EVAL_ACK(ack_drv & use3), .RES_VALID(rv_drv & use3), .RES_COUNT(rc_drv),
        .C1X(c1x3), .C1Y(c1y3), .C2X(c2x3), .C2Y(c2y3),
        .BUSY(busy3), .ITER(iter3), .DONE(done3)
    );

    // View of whichever scheduler is currently under test.
    logic req_m, sel_m, busy_m, done_m;
    logic [3:0] cx_m, cy_m, c1x_m, c1y_m, c2x_m, c2y_m, iter_m;
    assign req_m  = use3 ? req3  : req8;
    assign sel_m  = use3 ? sel3  : sel8;
    assign busy_m = use3 ? busy3 : busy8;
    assign done_m = use3 ? done3 : done8;
    assign cx_m   = use3 ? cx3   : cx8;
    assign cy_m   = use3 ? cy3   : cy8;
    assign c1x_m  = use3 ? c1x3  : c1x8;
    assign c1y_m  = use3 ? c1y3  : c1y8;
    assign c2x_m  = use3 ? c2x3  : c2x8;
    assign c2y_m  = use3 ? c2y3  : c2y8;
    assign iter_m = use3 ? iter3 : iter8;

    int n_checks = 0;
    int n_fail   = 0;

    // Engine configuration and bookkeeping.
    int mode, ack_delay, res_delay, stray_en;
    int acc_cnt, req_age, pend_cnt, pend_k, stab_err, stray_cnt;
    logic [3:0] pend_x, pend_y, prev_cx, prev_cy;
    logic pend_sel, prev_wait, prev_sel, prev_sel_m, snap_taken;
    logic [3:0] snap_c1x, snap_c1y, snap_c2x, snap_c2y, snap_iter;

    // Score tables: 0 basic, 1 tie, 2 peak at (k,k) on iteration k.
    function automatic logic [5:0] score(int m, logic [3:0] x, logic [3:0] y, logic s, int k);
        if (m == 0) begin
            if (!s) return (x == 4'd5 && y == 4'd7) ? 6'd10 : 6'd3;
            return (x == 4'd12 && y == 4'd3) ? 6'd12 : 6'd10;
        end else if (m == 1) begin
            if (!s) return ((x == 4'd3 && y == 4'd3) || (x == 4'd9 && y == 4'd9)) ? 6'd9 : 6'd0;
            return 6'd0;
        end
        return (int'(x) == k && int'(y) == k) ? 6'd20 : 6'd1;
    endfunction

    // Behavioural engine: all inputs change on the falling edge.
    initial begin
        ack_drv = 0; rv_drv = 0; rc_drv = 0;
        acc_cnt = 0; req_age = 0; pend_cnt = 0; pend_k = 0;
        stab_err = 0; stray_cnt = 0; prev_wait = 0; prev_sel_m = 0; snap_taken = 0;
        pend_x = 0; pend_y = 0; pend_sel = 0; prev_cx = 0; prev_cy = 0; prev_sel = 0;
        snap_c1x = 0; snap_c1y = 0; snap_c2x = 0; snap_c2y = 0; snap_iter = 0;
        forever begin
            @(negedge CLK);
            ack_drv = 0; rv_drv = 0; rc_drv = 0;
            if (RST || (start && !busy_m)) begin
                pend_cnt = 0; req_age = 0; acc_cnt = 0; prev_wait = 0;
                prev_sel_m = 0; snap_taken = 0; stab_err = 0; stray_cnt = 0;
            end else begin
                if (prev_wait && (!req_m || cx_m != prev_cx || cy_m != prev_cy || sel_m != prev_sel))
                    stab_err++;
                if (busy_m && prev_sel_m && !sel_m && !snap_taken) begin
                    snap_taken = 1;
                    snap_c1x = c1x_m; snap_c1y = c1y_m; snap_c2x = c2x_m; snap_c2y = c2y_m;
                    snap_iter = iter_m;
                end
                prev_sel_m = sel_m;
                if (pend_cnt > 0) begin
                    pend_cnt--;
                    if (pend_cnt == 0) begin
                        rv_drv = 1;
                        rc_drv = score(mode, pend_x, pend_y, pend_sel, pend_k);
                    end
                end
                prev_wait = 0;
                if (req_m) begin
                    if (req_age >= ack_delay) begin
                        ack_drv = 1;
                        pend_x = cx_m; pend_y = cy_m; pend_sel = sel_m;
                        pend_k = acc_cnt / 512 + 1;
                        acc_cnt++;
                        pend_cnt = res_delay;
                        req_age = 0;
                    end else begin
                        req_age++;
                        prev_wait = 1;
                        prev_cx = cx_m; prev_cy = cy_m; prev_sel = sel_m;
                        if (stray_en != 0 && !rv_drv) begin
                            rv_drv = 1; rc_drv = 6'd63; stray_cnt++;
                        end
                    end
                end
            end
        end
    end

    // Pulse START for one cycle and wait (bounded) for DONE, counting pulses.
    task automatic run_search(input int budget, output int cyc, output int ndone, output bit timeout);
        @(posedge CLK); #1 start = 1;
        @(posedge CLK); #1 start = 0;
        cyc = 0; ndone = 0; timeout = 1;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK); cyc++;
            if (done_m) begin ndone++; timeout = 0; break; end
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (done_m) ndone++;
        end
    endtask

    task automatic check_final(input string tag, input logic [3:0] e1x, input logic [3:0] e1y,
                               input logic [3:0] e2x, input logic [3:0] e2y, input logic [3:0] eiter,
                               input int ndone, input bit timeout);
        n_checks++;
        if (timeout !== 1'b0) begin n_fail++; $display("FAIL %s_timeout: DONE not seen within budget", tag); end
        n_checks++;
        if (ndone !== 1) begin n_fail++; $display("FAIL %s_done_pulses: got %0d expected 1", tag, ndone); end
        n_checks++;
        if ({c1x_m, c1y_m} !== {e1x, e1y}) begin n_fail++;
            $display("FAIL %s_c1: got (%0d,%0d) expected (%0d,%0d)", tag, c1x_m, c1y_m, e1x, e1y); end
        n_checks++;
        if ({c2x_m, c2y_m} !== {e2x, e2y}) begin n_fail++;
            $display("FAIL %s_c2: got (%0d,%0d) expected (%0d,%0d)", tag, c2x_m, c2y_m, e2x, e2y); end
        n_checks++;
        if (iter_m !== eiter) begin n_fail++; $display("FAIL %s_iter: got %0d expected %0d", tag, iter_m, eiter); end
        n_checks++;
        if (busy_m !== 1'b0) begin n_fail++; $display("FAIL %s_busy: got %b expected 0", tag, busy_m); end
        $display("%s: C1=(%0d,%0d) C2=(%0d,%0d) ITER=%0d", tag, c1x_m, c1y_m, c2x_m, c2y_m, iter_m);
    endtask

    task automatic test_reset();
        int nd;
        RST = 1; start = 0; use3 = 0;
        repeat (2) @(posedge CLK);
        #1 RST = 0;
        @(negedge CLK);
        n_checks++;
        if ({req8, cx8, cy8, sel8, c1x8, c1y8, c2x8, c2y8, busy8, iter8, done8} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {req8, cx8, cy8, sel8, c1x8, c1y8, c2x8, c2y8, busy8, iter8, done8});
        end
        nd = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (done8 || busy8) nd++;
        end
        n_checks++;
        if (nd !== 0) begin n_fail++; $display("FAIL reset_idle: DONE/BUSY seen %0d cycles expected 0", nd); end
        $display("reset: outputs checked, idle for 100 cycles");
    endtask

    task automatic test_basic();
        int cyc, nd; bit to;
        use3 = 0; mode = 0; ack_delay = 0; res_delay = 1; stray_en = 0;
        run_search(5000, cyc, nd, to);
        check_final("basic", 4'd5, 4'd7, 4'd12, 4'd3, 4'd2, nd, to);
        n_checks++;
        if (cyc < 2052 || cyc > 2054) begin n_fail++;
            $display("FAIL basic_cycles: got %0d expected 2053 +/-1", cyc); end
        n_checks++;
        if (!snap_taken || {snap_c1x, snap_c1y, snap_c2x, snap_c2y, snap_iter} !== {4'd5, 4'd7, 4'd12, 4'd3, 4'd1}) begin
            n_fail++;
            $display("FAIL basic_iter1: got taken=%b C1=(%0d,%0d) C2=(%0d,%0d) ITER=%0d expected (5,7) (12,3) 1",
                     snap_taken, snap_c1x, snap_c1y, snap_c2x, snap_c2y, snap_iter);
        end
        $display("basic: START->DONE %0d cycles", cyc);
    endtask

    task automatic test_tie();
        int cyc, nd; bit to;
        use3 = 0; mode = 1; ack_delay = 0; res_delay = 1; stray_en = 0;
        run_search(5000, cyc, nd, to);
        check_final("tie", 4'd3, 4'd3, 4'd0, 4'd0, 4'd2, nd, to);
    endtask

    task automatic test_backpressure();
        int cyc, nd; bit to;
        use3 = 0; mode = 0; ack_delay = 3; res_delay = 4; stray_en = 1;
        run_search(20000, cyc, nd, to);
        check_final("backpressure", 4'd5, 4'd7, 4'd12, 4'd3, 4'd2, nd, to);
        n_checks++;
        if (stab_err !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", stab_err); end
        n_checks++;
        if (stray_cnt < 1000) begin n_fail++; $display("FAIL bp_stray_count: got %0d expected >= 1000", stray_cnt); end
        stray_en = 0; ack_delay = 0; res_delay = 1;
    endtask

    task automatic test_non_convergence();
        int cyc, nd; bit to;
        use3 = 1; mode = 2; ack_delay = 0; res_delay = 1; stray_en = 0;
        run_search(8000, cyc, nd, to);
        check_final("nonconv", 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, nd, to);
        n_checks++;
        if (!snap_taken || {snap_c1x, snap_c1y, snap_c2x, snap_c2y} !== {4'd1, 4'd1, 4'd1, 4'd1}) begin
            n_fail++;
            $display("FAIL nonconv_iter1: got C1=(%0d,%0d) C2=(%0d,%0d) expected (1,1) (1,1)",
                     snap_c1x, snap_c1y, snap_c2x, snap_c2y);
        end
        use3 = 0;
    endtask

    task automatic test_abort_restart();
        int cyc, nd, waited; bit to;
        logic [7:0] cand0;
        use3 = 0; mode = 0; ack_delay = 0; res_delay = 1; stray_en = 0;
        @(posedge CLK); #1 start = 1;
        @(posedge CLK); #1 start = 0;
        waited = 0;
        while (!sel8 && waited < 2000) begin @(negedge CLK); waited++; end
        n_checks++;
        if (sel8 !== 1'b1) begin n_fail++; $display("FAIL abort_reach_c2: got SEL=%b expected 1", sel8); end
        repeat (50) @(negedge CLK);
        cand0 = {cy8, cx8};
        @(posedge CLK); #1 start = 1;
        @(posedge CLK); #1 start = 0;
        @(negedge CLK); @(negedge CLK);
        n_checks++;
        if (sel8 !== 1'b1 || {cy8, cx8} <= cand0 || busy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_start_ignored: got SEL=%b cand=%h BUSY=%b expected SEL=1 cand>%h BUSY=1",
                     sel8, {cy8, cx8}, busy8, cand0);
        end
        @(posedge CLK); #1 RST = 1;
        @(posedge CLK); #1 RST = 0;
        @(negedge CLK);
        n_checks++;
        if ({req8, cx8, cy8, sel8, c1x8, c1y8, c2x8, c2y8, busy8, iter8, done8} !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_outputs: got %h expected 0",
                     {req8, cx8, cy8, sel8, c1x8, c1y8, c2x8, c2y8, busy8, iter8, done8});
        end
        nd = 0;
        for (int i = 0; i < 50; i++) begin @(negedge CLK); if (done8) nd++; end
        n_checks++;
        if (nd !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", nd); end
        $display("abort: mid-C2 reset cleared outputs, candidate before busy START %h", cand0);
        run_search(5000, cyc, nd, to);
        check_final("restart", 4'd5, 4'd7, 4'd12, 4'd3, 4'd2, nd, to);
    endtask

    initial begin
        RST = 1; start = 0; use3 = 0;
        mode = 0; ack_delay = 0; res_delay = 1; stray_en = 0;
        test_reset();
        test_basic();
        test_tie();
        test_backpressure();
        test_non_convergence();
        test_abort_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
